// File: rtl/cpu_pkg.sv
// Shared constants, types and helpers for the cpu_stepper timing block.
package cpu_pkg;

  localparam int unsigned PHASE_W = 2;

  localparam logic [PHASE_W-1:0] PH_0 = 2'd0;
  localparam logic [PHASE_W-1:0] PH_1 = 2'd1;
  localparam logic [PHASE_W-1:0] PH_2 = 2'd2;
  localparam logic [PHASE_W-1:0] PH_3 = 2'd3;

  localparam int unsigned NUM_STEPS_DEFAULT = 6;
  localparam int unsigned MAX_STEPS         = 8;

  // Single-step controller states (only used when single-step is built in).
  typedef enum logic [0:0] {
    StIdle,
    StStep
  } ss_state_e;

  // One-hot rotate left; the bit at index 'last' wraps back to bit 0.
  function automatic logic [MAX_STEPS-1:0] onehot_rotl(input logic [MAX_STEPS-1:0] v,
                                                       input logic [2:0]           last);
    logic [MAX_STEPS-1:0] r;
    if (v[last]) begin
      r    = '0;
      r[0] = 1'b1;
    end else begin
      r = {v[MAX_STEPS-2:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_phase_gen.sv
// Four-phase counter with run gating and registered clk_e / clk_s decode.
// step_tick is asserted in the cycle whose rising edge performs the 3->0
// phase transition, so the step register can advance on that same edge.
module cpu_phase_gen
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  output logic [PHASE_W-1:0] phase,
  output logic               clk_e,
  output logic               clk_s,
  output logic               running,
  output logic               step_tick
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               clk_e_q, clk_s_q, running_q;

  // Next phase: advance while enabled, hold while frozen.
  always_comb begin
    phase_d   = phase_q;
    step_tick = 1'b0;
    if (adv) begin
      phase_d   = phase_q + 2'd1;
      step_tick = (phase_q == PH_3);
    end
  end

  // Strobes decode from the next phase so they line up with the phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_0;
      clk_e_q   <= 1'b0;
      clk_s_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk_e_q   <= adv && (phase_d != PH_0);
      clk_s_q   <= adv && (phase_d == PH_2);
      running_q <= adv;
    end
  end

  assign phase   = phase_q;
  assign clk_e   = clk_e_q;
  assign clk_s   = clk_s_q;
  assign running = running_q;

endmodule

// File: rtl/cpu_stepper.sv
// Instruction step sequencer: one-hot step register, sticky early-return
// request, instr_done pulse and phase timing via cpu_phase_gen.
// Optional single-step control is built in when CPU_STEPPER_SINGLE_STEP_EN
// is defined (adds the step_req input).
module cpu_stepper
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_clr,
`ifdef CPU_STEPPER_SINGLE_STEP_EN
  input  logic                 step_req,
`endif
  output logic [NUM_STEPS-1:0] step,
  output logic [PHASE_W-1:0]   phase,
  output logic                 clk_e,
  output logic                 clk_s,
  output logic                 instr_done,
  output logic                 running
);

  localparam logic [2:0]           LastIdx   = 3'(NUM_STEPS - 1);
  localparam logic [NUM_STEPS-1:0] StepFirst = NUM_STEPS'(1);

  logic                 adv;
  logic                 tick;
  logic [NUM_STEPS-1:0] step_q, step_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 done_q, done_d;
  logic [MAX_STEPS-1:0] step_wide, step_rot;

`ifdef CPU_STEPPER_SINGLE_STEP_EN
  ss_state_e ss_q, ss_d;
  logic      req_q;
  logic      ss_start;

  // A step_req rising edge while frozen runs the sequencer until the next boundary.
  always_comb begin
    ss_start = (ss_q == StIdle) && !run && step_req && !req_q;
    adv      = run || ss_start || (ss_q == StStep);
    ss_d     = ss_q;
    unique case (ss_q)
      StIdle: if (ss_start && !tick) ss_d = StStep;
      StStep: if (tick) ss_d = StIdle;
    endcase
  end

  // Single-step state and step_req edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q  <= StIdle;
      req_q <= 1'b0;
    end else begin
      ss_q  <= ss_d;
      req_q <= step_req;
    end
  end
`else
  assign adv = run;
`endif

  cpu_phase_gen u_phase_gen (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .phase     (phase),
    .clk_e     (clk_e),
    .clk_s     (clk_s),
    .running   (running),
    .step_tick (tick)
  );

  // Step advance / early return at the boundary; step_clr is sticky until used.
  always_comb begin
    step_wide                = '0;
    step_wide[NUM_STEPS-1:0] = step_q;
    step_rot                 = onehot_rotl(step_wide, LastIdx);
    step_d                   = step_q;
    done_d                   = 1'b0;
    clr_pend_d               = clr_pend_q || step_clr;
    if (tick) begin
      clr_pend_d = 1'b0;
      if (clr_pend_q || step_clr) begin
        step_d = StepFirst;
        done_d = 1'b1;
      end else begin
        step_d = step_rot[NUM_STEPS-1:0];
        done_d = step_q[NUM_STEPS-1];
      end
    end
  end

  // Step register, pending early-return flag and instr_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q     <= StepFirst;
      clr_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_q     <= step_d;
      clr_pend_q <= clr_pend_d;
      done_q     <= done_d;
    end
  end

  assign step       = step_q;
  assign instr_done = done_q;

endmodule

// File: tb/tb_cpu_stepper.sv
// Self-checking bench for cpu_stepper (NUM_STEPS = 6). A behavioural model
// pushes the expected registered state each cycle; the value is popped and
// compared one edge later. A segment table checks hand-derived end states.
module tb_cpu_stepper;

  logic       clk;
  logic       rst;
  logic       run;
  logic       step_clr;
  logic [5:0] step;
  logic [1:0] phase;
  logic       clk_e;
  logic       clk_s;
  logic       instr_done;
  logic       running;
`ifdef CPU_STEPPER_SINGLE_STEP_EN
  logic       step_req;
`endif

  cpu_stepper dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step_clr   (step_clr),
`ifdef CPU_STEPPER_SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .step       (step),
    .phase      (phase),
    .clk_e      (clk_e),
    .clk_s      (clk_s),
    .instr_done (instr_done),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ph;
    logic [5:0] st;
    logic       e;
    logic       s;
    logic       done;
    logic       run;
  } exp_t;

  typedef struct {
    logic       run;
    logic       clr;
    int         n;
    logic [1:0] ph;
    logic [5:0] st;
    logic       e;
    logic       s;
    logic       done;
  } seg_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [1:0] m_phase;
  logic [5:0] m_step;
  logic       m_pend, m_e, m_s, m_done, m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 2'd0;
    m_step  = 6'b000001;
    m_pend  = 1'b0;
    m_e     = 1'b0;
    m_s     = 1'b0;
    m_done  = 1'b0;
    m_run   = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic c);
    logic hit;
    hit = m_pend | c;
    if (r) begin
      if (m_phase == 2'd3) begin
        m_pend = 1'b0;
        if (hit) begin
          m_done = 1'b1;
          m_step = 6'b000001;
        end else begin
          m_done = m_step[5];
          m_step = m_step[5] ? 6'b000001 : {m_step[4:0], 1'b0};
        end
      end else begin
        m_done = 1'b0;
        m_pend = hit;
      end
      m_phase = m_phase + 2'd1;
      m_e     = (m_phase != 2'd0);
      m_s     = (m_phase == 2'd2);
      m_run   = 1'b1;
    end else begin
      m_pend = hit;
      m_e    = 1'b0;
      m_s    = 1'b0;
      m_done = 1'b0;
      m_run  = 1'b0;
    end
  endtask

  // One clock: drive inputs, push expectation, sample after the edge, compare.
  task automatic apply(input logic r, input logic c);
    exp_t e;
    exp_t got;
    run      = r;
    step_clr = c;
    model_step(r, c);
    e = '{ph: m_phase, st: m_step, e: m_e, s: m_s, done: m_done, run: m_run};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = '{ph: phase, st: step, e: clk_e, s: clk_s, done: instr_done, run: running};
    e   = sb.pop_front();
    chk("cycle_state", 32'(got), 32'(e));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'h01);
    chk({tag, "_clk_e"}, 32'(clk_e), 32'd0);
    chk({tag, "_clk_s"}, 32'(clk_s), 32'd0);
    chk({tag, "_instr_done"}, 32'(instr_done), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
  endtask

  seg_t segs[14];

  initial begin
    segs[0]  = '{1'b1, 1'b0, 24, 2'd0, 6'b000001, 1'b0, 1'b0, 1'b1};
    segs[1]  = '{1'b1, 1'b0,  9, 2'd1, 6'b000100, 1'b1, 1'b0, 1'b0};
    segs[2]  = '{1'b1, 1'b1,  1, 2'd2, 6'b000100, 1'b1, 1'b1, 1'b0};
    segs[3]  = '{1'b1, 1'b0,  2, 2'd0, 6'b000001, 1'b0, 1'b0, 1'b1};
    segs[4]  = '{1'b1, 1'b0,  6, 2'd2, 6'b000010, 1'b1, 1'b1, 1'b0};
    segs[5]  = '{1'b0, 1'b0,  5, 2'd2, 6'b000010, 1'b0, 1'b0, 1'b0};
    segs[6]  = '{1'b1, 1'b0,  1, 2'd3, 6'b000010, 1'b1, 1'b0, 1'b0};
    segs[7]  = '{1'b1, 1'b0,  1, 2'd0, 6'b000100, 1'b0, 1'b0, 1'b0};
    segs[8]  = '{1'b0, 1'b1,  1, 2'd0, 6'b000100, 1'b0, 1'b0, 1'b0};
    segs[9]  = '{1'b0, 1'b0,  3, 2'd0, 6'b000100, 1'b0, 1'b0, 1'b0};
    segs[10] = '{1'b1, 1'b0,  4, 2'd0, 6'b000001, 1'b0, 1'b0, 1'b1};
    segs[11] = '{1'b1, 1'b0,  3, 2'd3, 6'b000001, 1'b1, 1'b0, 1'b0};
    segs[12] = '{1'b1, 1'b1,  1, 2'd0, 6'b000001, 1'b0, 1'b0, 1'b1};
    segs[13] = '{1'b1, 1'b0, 17, 2'd1, 6'b010000, 1'b1, 1'b0, 1'b0};

    rst      = 1'b1;
    run      = 1'b0;
    step_clr = 1'b0;
`ifdef CPU_STEPPER_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    model_reset();
    #12;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Segment table: walk, early return, freeze, sticky clear, boundary clear
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < segs[i].n; k++) apply(segs[i].run, (k == 0) ? segs[i].clr : 1'b0);
      chk($sformatf("seg%0d_phase", i), 32'(phase), 32'(segs[i].ph));
      chk($sformatf("seg%0d_step", i), 32'(step), 32'(segs[i].st));
      chk($sformatf("seg%0d_clk_e", i), 32'(clk_e), 32'(segs[i].e));
      chk($sformatf("seg%0d_clk_s", i), 32'(clk_s), 32'(segs[i].s));
      chk($sformatf("seg%0d_instr_done", i), 32'(instr_done), 32'(segs[i].done));
    end

    // Asynchronous reset between edges, at step 5 phase 1
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    #1;
    rst = 1'b0;
    model_reset();

    // Random run/step_clr with invariant checks
    for (int i = 0; i < 1000; i++) begin
      logic r, c;
      r = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 15) == 0);
      apply(r, c);
      chk("inv_onehot", 32'($onehot(step)), 32'd1);
      chk("inv_s_implies_e", 32'(!clk_s || clk_e), 32'd1);
      if (!r) chk("inv_no_done_frozen", 32'(instr_done), 32'd0);
    end

`ifdef CPU_STEPPER_SINGLE_STEP_EN
    // Single step from step 1 phase 0 while frozen
    run      = 1'b0;
    step_clr = 1'b0;
    rst      = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step_req = 1'b1;
    @(posedge clk);
    #1;
    step_req = 1'b0;
    chk("ss_e1", 32'(clk_e), 32'd1);
    chk("ss_s1", 32'(clk_s), 32'd0);
    @(posedge clk);
    #1;
    chk("ss_e2", 32'(clk_e), 32'd1);
    chk("ss_s2", 32'(clk_s), 32'd1);
    @(posedge clk);
    #1;
    chk("ss_e3", 32'(clk_e), 32'd1);
    chk("ss_s3", 32'(clk_s), 32'd0);
    @(posedge clk);
    #1;
    chk("ss_e4", 32'(clk_e), 32'd0);
    chk("ss_step4", 32'(step), 32'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("ss_frozen_phase", 32'(phase), 32'd0);
    chk("ss_frozen_step", 32'(step), 32'h02);
    chk("ss_frozen_e", 32'(clk_e), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
